// File: rtl/attn_tile_sequencer_if.sv
// Operand bus between the tile sequencer and the systolic-array wrapper.
// The master side sequences tiles and streams vector pairs; the slave side
// provides backpressure and reports tile completion.
interface attn_tile_sequencer_if #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16
);
    logic                   vector_vld;
    logic                   vector_rdy;
    logic [SA_R*D_W-1:0]    vector_1;
    logic [SA_C*D_W-1:0]    vector_2;
    logic                   tile_start;
    logic [15:0]            tile_row;
    logic [15:0]            tile_col;
    logic                   sa_done;

    modport master (
        output vector_vld, vector_1, vector_2, tile_start, tile_row, tile_col,
        input  vector_rdy, sa_done
    );

    modport slave (
        input  vector_vld, vector_1, vector_2, tile_start, tile_row, tile_col,
        output vector_rdy, sa_done
    );
endinterface

// File: rtl/attn_tile_sequencer.sv
// Tile-level operand sequencer for the attention datapath.
// Walks the output matrix of S = Q*K^T (mode 0) or O = P*V (mode 1) in
// SA_R x SA_C tiles, streaming K_IN inner-dimension vector pairs per tile and
// then waiting for the array to drain before moving on.
module attn_tile_sequencer #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16,
    parameter int SEQ  = 64,
    parameter int D_K  = 64
) (
    input  logic                    I_CLK,
    input  logic                    I_SYNC_RST,
    input  logic                    I_START,
    input  logic                    I_MODE,
    input  logic [SEQ*D_K*D_W-1:0]  I_MAT_Q,
    input  logic [SEQ*D_K*D_W-1:0]  I_MAT_K,
    input  logic [SEQ*SEQ*D_W-1:0]  I_MAT_P,
    input  logic [SEQ*D_K*D_W-1:0]  I_MAT_V,
    attn_tile_sequencer_if.master   sa,
    output logic                    O_BUSY,
    output logic                    O_DONE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FEED = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] TR_LAST    = 16'(SEQ / SA_R - 1);
    localparam logic [15:0] TC_LAST_M0 = 16'(SEQ / SA_C - 1);
    localparam logic [15:0] TC_LAST_M1 = 16'(D_K / SA_C - 1);
    localparam logic [15:0] K_LAST_M0  = 16'(D_K - 1);
    localparam logic [15:0] K_LAST_M1  = 16'(SEQ - 1);

    logic [1:0]  state_reg, state_next;
    logic [15:0] k_reg, k_next;
    logic [15:0] tr_reg, tr_next;
    logic [15:0] tc_reg, tc_next;
    logic        mode_reg, mode_next;
    logic        first_reg, first_next;   // first FEED cycle of the current tile

    logic [15:0] k_last;
    logic [15:0] tc_last;
    logic        feeding;

    assign k_last  = mode_reg ? K_LAST_M1  : K_LAST_M0;
    assign tc_last = mode_reg ? TC_LAST_M1 : TC_LAST_M0;
    assign feeding = (state_reg == S_FEED);

    // Next-state and counter logic for the tile walk.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        tr_next    = tr_reg;
        tc_next    = tc_reg;
        mode_next  = mode_reg;
        first_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (I_START) begin
                    mode_next  = I_MODE;
                    k_next     = '0;
                    tr_next    = '0;
                    tc_next    = '0;
                    first_next = 1'b1;
                    state_next = S_FEED;
                end
            end
            S_FEED: begin
                if (sa.vector_rdy) begin
                    if (k_reg == k_last) begin
                        k_next     = '0;
                        state_next = S_WAIT;
                    end else begin
                        k_next = k_reg + 16'd1;
                    end
                end
            end
            S_WAIT: begin
                if (sa.sa_done) begin
                    if (tr_reg == TR_LAST && tc_reg == tc_last) begin
                        state_next = S_DONE;
                    end else begin
                        first_next = 1'b1;
                        state_next = S_FEED;
                        if (tc_reg == tc_last) begin
                            tc_next = '0;
                            tr_next = tr_reg + 16'd1;
                        end else begin
                            tc_next = tc_reg + 16'd1;
                        end
                    end
                end
            end
            default: begin
                // Leave the tile indices at zero so the idle bus is quiet.
                tr_next    = '0;
                tc_next    = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state_reg <= S_IDLE;
            k_reg     <= '0;
            tr_reg    <= '0;
            tc_reg    <= '0;
            mode_reg  <= 1'b0;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            tr_reg    <= tr_next;
            tc_reg    <= tc_next;
            mode_reg  <= mode_next;
            first_reg <= first_next;
        end
    end

    assign sa.vector_vld = feeding;
    assign sa.tile_start = feeding && first_reg;
    assign sa.tile_row   = tr_reg;
    assign sa.tile_col   = tc_reg;
    assign O_BUSY        = (state_reg == S_FEED) || (state_reg == S_WAIT);
    assign O_DONE        = (state_reg == S_DONE);

    // A-operand lanes: lane i carries A[tr*SA_R+i][k] (A = Q or P).
    for (genvar gi = 0; gi < SA_R; gi++) begin : g_lane_a
        logic [D_W-1:0] lane_val;
        int unsigned    a_row;
        always_comb begin
            a_row    = 32'(tr_reg) * 32'(SA_R) + 32'(gi);
            lane_val = '0;
            if (feeding) begin
                if (mode_reg) begin
                    lane_val = I_MAT_P[(a_row * 32'(SEQ) + 32'(k_reg)) * 32'(D_W) +: D_W];
                end else begin
                    lane_val = I_MAT_Q[(a_row * 32'(D_K) + 32'(k_reg)) * 32'(D_W) +: D_W];
                end
            end
        end
        assign sa.vector_1[gi*D_W +: D_W] = lane_val;
    end

    // B-operand lanes: lane j carries B[k][tc*SA_C+j]; in mode 0 B = K^T,
    // so the transpose is just a different index into K.
    for (genvar gi = 0; gi < SA_C; gi++) begin : g_lane_b
        logic [D_W-1:0] lane_val;
        int unsigned    b_col;
        always_comb begin
            b_col    = 32'(tc_reg) * 32'(SA_C) + 32'(gi);
            lane_val = '0;
            if (feeding) begin
                if (mode_reg) begin
                    lane_val = I_MAT_V[(32'(k_reg) * 32'(D_K) + b_col) * 32'(D_W) +: D_W];
                end else begin
                    lane_val = I_MAT_K[(b_col * 32'(D_K) + 32'(k_reg)) * 32'(D_W) +: D_W];
                end
            end
        end
        assign sa.vector_2[gi*D_W +: D_W] = lane_val;
    end

endmodule

// File: tb/tb_attn_tile_sequencer.sv
// Self-checking bench for attn_tile_sequencer with a small 4x2 geometry.
// Expected beats come from matrix arrays indexed by the tile/beat rules.
module tb_attn_tile_sequencer;

    localparam int D_W  = 16;
    localparam int SA_R = 2;
    localparam int SA_C = 2;
    localparam int SEQ  = 4;
    localparam int D_K  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   srst;
    logic                   start;
    logic                   mode;
    logic [SEQ*D_K*D_W-1:0] mat_q, mat_k, mat_v;
    logic [SEQ*SEQ*D_W-1:0] mat_p;
    logic                   busy, done;

    attn_tile_sequencer_if #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) sa_bus ();

    attn_tile_sequencer #(
        .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .SEQ(SEQ), .D_K(D_K)
    ) dut (
        .I_CLK      (clk),
        .I_SYNC_RST (srst),
        .I_START    (start),
        .I_MODE     (mode),
        .I_MAT_Q    (mat_q),
        .I_MAT_K    (mat_k),
        .I_MAT_P    (mat_p),
        .I_MAT_V    (mat_v),
        .sa         (sa_bus.master),
        .O_BUSY     (busy),
        .O_DONE     (done)
    );

    int q [SEQ][D_K];
    int km[SEQ][D_K];
    int v [SEQ][D_K];
    int p [SEQ][SEQ];

    int total = 0;
    int bad   = 0;

    task automatic pack_mats();
        for (int r = 0; r < SEQ; r++) begin
            for (int c = 0; c < D_K; c++) begin
                mat_q[(r*D_K+c)*D_W +: D_W] = D_W'(q[r][c]);
                mat_k[(r*D_K+c)*D_W +: D_W] = D_W'(km[r][c]);
                mat_v[(r*D_K+c)*D_W +: D_W] = D_W'(v[r][c]);
            end
            for (int c = 0; c < SEQ; c++) mat_p[(r*SEQ+c)*D_W +: D_W] = D_W'(p[r][c]);
        end
    endtask

    task automatic load_plan();
        for (int r = 0; r < SEQ; r++) begin
            for (int c = 0; c < D_K; c++) begin
                q[r][c]  = 10*r + c;
                km[r][c] = 20 + 10*r + c;
                v[r][c]  = 30 + 10*r + c;
            end
            for (int c = 0; c < SEQ; c++) p[r][c] = r*4 + c;
        end
        pack_mats();
    endtask

    task automatic load_random();
        for (int r = 0; r < SEQ; r++) begin
            for (int c = 0; c < D_K; c++) begin
                q[r][c]  = int'($urandom_range(0, 65535));
                km[r][c] = int'($urandom_range(0, 65535));
                v[r][c]  = int'($urandom_range(0, 65535));
            end
            for (int c = 0; c < SEQ; c++) p[r][c] = int'($urandom_range(0, 65535));
        end
        pack_mats();
    endtask

    // Lane i = A[tr*SA_R+i][k], A = Q (mode 0) or P (mode 1).
    function automatic logic [SA_R*D_W-1:0] exp_v1(input bit m, input int tr, input int kk);
        logic [SA_R*D_W-1:0] res;
        res = '0;
        for (int i = 0; i < SA_R; i++) begin
            if (m) res[i*D_W +: D_W] = D_W'(p[tr*SA_R+i][kk]);
            else   res[i*D_W +: D_W] = D_W'(q[tr*SA_R+i][kk]);
        end
        return res;
    endfunction

    // Lane j = B[k][tc*SA_C+j], B = K^T (mode 0) or V (mode 1).
    function automatic logic [SA_C*D_W-1:0] exp_v2(input bit m, input int tc, input int kk);
        logic [SA_C*D_W-1:0] res;
        res = '0;
        for (int j = 0; j < SA_C; j++) begin
            if (m) res[j*D_W +: D_W] = D_W'(v[kk][tc*SA_C+j]);
            else   res[j*D_W +: D_W] = D_W'(km[tc*SA_C+j][kk]);
        end
        return res;
    endfunction

    // Drives one complete job and checks every cycle against the tile walk.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // abort_at: global beat index at which reset is asserted (-1 = never).
    task automatic run_job(input bit m, input int rdy_mode, input int delay,
                           input bit noise, input int abort_at, input string tag);
        int kin, ntc, ntr, beat_idx, pat, acc_cnt, ts_cnt;
        bit first, acc, r;
        logic [SA_R*D_W-1:0] e1;
        logic [SA_C*D_W-1:0] e2;
        kin = m ? SEQ : D_K;
        ntc = m ? D_K / SA_C : SEQ / SA_C;
        ntr = SEQ / SA_R;
        beat_idx = 0; pat = 0; acc_cnt = 0;

        @(negedge clk);
        mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int tr = 0; tr < ntr; tr++) begin
            for (int tc = 0; tc < ntc; tc++) begin
                ts_cnt = 0;
                first  = 1'b1;
                for (int kk = 0; kk < kin; kk++) begin
                    acc = 1'b0;
                    while (!acc) begin
                        e1 = exp_v1(m, tr, kk);
                        e2 = exp_v2(m, tc, kk);
                        total++;
                        if (sa_bus.vector_vld !== 1'b1) begin
                            bad++; $display("FAIL %s vld t(%0d,%0d) k%0d got=%b exp=1", tag, tr, tc, kk, sa_bus.vector_vld);
                        end
                        total++;
                        if (busy !== 1'b1 || done !== 1'b0) begin
                            bad++; $display("FAIL %s busy/done feed got=%b/%b exp=1/0", tag, busy, done);
                        end
                        total++;
                        if (sa_bus.tile_row !== 16'(tr) || sa_bus.tile_col !== 16'(tc)) begin
                            bad++; $display("FAIL %s tile idx got=(%0d,%0d) exp=(%0d,%0d)", tag, sa_bus.tile_row, sa_bus.tile_col, tr, tc);
                        end
                        total++;
                        if (sa_bus.tile_start !== first) begin
                            bad++; $display("FAIL %s tile_start t(%0d,%0d) k%0d got=%b exp=%b", tag, tr, tc, kk, sa_bus.tile_start, first);
                        end
                        total++;
                        if (sa_bus.vector_1 !== e1 || sa_bus.vector_2 !== e2) begin
                            bad++; $display("FAIL %s data t(%0d,%0d) k%0d got=%h/%h exp=%h/%h", tag, tr, tc, kk, sa_bus.vector_1, sa_bus.vector_2, e1, e2);
                        end
                        if (sa_bus.tile_start === 1'b1) ts_cnt++;

                        if (beat_idx == abort_at) begin
                            srst = 1'b1; sa_bus.vector_rdy = 1'b1; start = 1'b0; sa_bus.sa_done = 1'b0;
                            @(negedge clk);
                            srst = 1'b0; sa_bus.vector_rdy = 1'b0;
                            total++;
                            if (sa_bus.vector_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                                sa_bus.tile_start !== 1'b0 || sa_bus.tile_row !== 16'd0 || sa_bus.tile_col !== 16'd0 ||
                                sa_bus.vector_1 !== '0 || sa_bus.vector_2 !== '0) begin
                                bad++; $display("FAIL %s after abort vld=%b busy=%b done=%b ts=%b row=%0d col=%0d v1=%h v2=%h exp all 0",
                                    tag, sa_bus.vector_vld, busy, done, sa_bus.tile_start, sa_bus.tile_row, sa_bus.tile_col, sa_bus.vector_1, sa_bus.vector_2);
                            end
                            for (int i = 0; i < 3; i++) begin
                                sa_bus.sa_done = (i == 0);
                                @(negedge clk);
                                total++;
                                if (done !== 1'b0 || busy !== 1'b0 || sa_bus.vector_vld !== 1'b0) begin
                                    bad++; $display("FAIL %s post-abort idle done=%b busy=%b vld=%b exp 0/0/0", tag, done, busy, sa_bus.vector_vld);
                                end
                            end
                            sa_bus.sa_done = 1'b0;
                            $display("job %s: aborted at beat %0d", tag, beat_idx);
                            return;
                        end

                        case (rdy_mode)
                            0:       r = 1'b1;
                            1:       r = ((pat % 4) == 0) || ((pat % 4) == 3);
                            default: r = 1'($urandom_range(0, 1));
                        endcase
                        pat++;
                        sa_bus.vector_rdy = r;
                        sa_bus.sa_done    = noise && ($urandom_range(0, 2) == 0);
                        start             = noise && ($urandom_range(0, 3) == 0);
                        if (r && sa_bus.vector_vld === 1'b1) acc_cnt++;
                        @(negedge clk);
                        first = 1'b0;
                        acc   = r;
                    end
                    beat_idx++;
                end
                sa_bus.vector_rdy = 1'b0; sa_bus.sa_done = 1'b0; start = 1'b0;
                total++;
                if (ts_cnt != 1) begin
                    bad++; $display("FAIL %s tile_start count t(%0d,%0d) got=%0d exp=1", tag, tr, tc, ts_cnt);
                end
                for (int d = 0; d <= delay; d++) begin
                    total++;
                    if (sa_bus.vector_vld !== 1'b0 || sa_bus.vector_1 !== '0 || sa_bus.vector_2 !== '0 ||
                        busy !== 1'b1 || done !== 1'b0 || sa_bus.tile_start !== 1'b0) begin
                        bad++; $display("FAIL %s wait t(%0d,%0d) vld=%b v1=%h v2=%h busy=%b done=%b ts=%b exp 0/0/0/1/0/0",
                            tag, tr, tc, sa_bus.vector_vld, sa_bus.vector_1, sa_bus.vector_2, busy, done, sa_bus.tile_start);
                    end
                    if (d == delay) begin
                        sa_bus.sa_done = 1'b1; start = 1'b0;
                    end else begin
                        start = noise && ($urandom_range(0, 2) == 0);
                    end
                    @(negedge clk);
                end
                sa_bus.sa_done = 1'b0; start = 1'b0;
            end
        end

        total++;
        if (acc_cnt != ntr*ntc*kin) begin
            bad++; $display("FAIL %s accepted beats got=%0d exp=%0d", tag, acc_cnt, ntr*ntc*kin);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sa_bus.vector_vld !== 1'b0) begin
            bad++; $display("FAIL %s done pulse done=%b busy=%b vld=%b exp 1/0/0", tag, done, busy, sa_bus.vector_vld);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s after done done=%b busy=%b exp 0/0", tag, done, busy);
        end
        $display("job %s: mode=%0d beats=%0d done", tag, m, acc_cnt);
    endtask

    task automatic test_reset();
        srst = 1'b1; start = 1'b0; mode = 1'b0;
        sa_bus.vector_rdy = 1'b0; sa_bus.sa_done = 1'b0;
        load_plan();
        repeat (3) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        total++;
        if (sa_bus.vector_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sa_bus.tile_start !== 1'b0 ||
            sa_bus.tile_row !== 16'd0 || sa_bus.tile_col !== 16'd0 || sa_bus.vector_1 !== '0 || sa_bus.vector_2 !== '0) begin
            bad++; $display("FAIL reset outputs vld=%b busy=%b done=%b ts=%b row=%0d col=%0d exp all 0",
                sa_bus.vector_vld, busy, done, sa_bus.tile_start, sa_bus.tile_row, sa_bus.tile_col);
        end
        $display("test_reset: checked");
    endtask

    task automatic test_mode0_basic();
        load_plan();
        run_job(1'b0, 0, 2, 1'b0, -1, "mode0_basic");
    endtask

    task automatic test_mode1();
        load_plan();
        run_job(1'b1, 0, 2, 1'b0, -1, "mode1");
    endtask

    task automatic test_backpressure();
        load_plan();
        run_job(1'b0, 1, 2, 1'b0, -1, "backpressure");
    endtask

    task automatic test_ignored_inputs();
        load_plan();
        run_job(1'b0, 0, 2, 1'b1, -1, "ignored_inputs");
    endtask

    task automatic test_reset_abort();
        load_plan();
        run_job(1'b0, 0, 2, 1'b0, 5, "abort");
        run_job(1'b0, 0, 2, 1'b0, -1, "after_abort");
    endtask

    task automatic test_start_latency();
        load_plan();
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || sa_bus.vector_vld !== 1'b0) begin
            bad++; $display("FAIL start_latency idle busy=%b vld=%b exp 0/0", busy, sa_bus.vector_vld);
        end
        run_job(1'b0, 0, 0, 1'b0, -1, "start_latency");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            load_random();
            run_job(1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 3)), 1'b1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode1();
        test_backpressure();
        test_ignored_inputs();
        test_reset_abort();
        test_start_latency();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/attn_tile_sequencer.md
Name: attn_tile_sequencer

Overview:
Tile-level operand sequencer for the attention datapath, successor to the fixed single-pass Q/K/V vector feeder.
- Walks the full output matrix of either S = Q·K^T (mode 0) or O = P·V (mode 1) in SA_R×SA_C tiles.
- For each tile, streams the inner-dimension row/column vector pairs into the systolic array with valid/ready backpressure, then waits for the array to report completion.
- Sits between the attention top level (which holds Q/K/V/P) and the SA wrapper.

Parameters:
- D_W, 16, element width in bits
- SA_R, 16, systolic array rows (lanes of O_VECTOR_1)
- SA_C, 16, systolic array columns (lanes of O_VECTOR_2)
- SEQ, 64, sequence length; must be a multiple of SA_R and SA_C
- D_K, 64, per-head dimension; must be a multiple of SA_C

Ports:
- I_CLK, in, 1, clock
- I_SYNC_RST, in, 1, synchronous active-high reset
- I_START, in, 1, start pulse; sampled in IDLE only
- I_MODE, in, 1, 0 = Q·K^T, 1 = P·V; sampled with I_START
- I_MAT_Q, in, SEQ*D_K*D_W, Q matrix, row-major
- I_MAT_K, in, SEQ*D_K*D_W, K matrix, row-major
- I_MAT_P, in, SEQ*SEQ*D_W, softmax probability matrix, row-major
- I_MAT_V, in, SEQ*D_K*D_W, V matrix, row-major
- I_VECTOR_RDY, in, 1, SA wrapper accepts the current vector pair
- I_SA_DONE, in, 1, SA wrapper pulse: current tile drained
- O_VECTOR_VLD, out, 1, vector pair valid
- O_VECTOR_1, out, SA_R*D_W, A-operand column slice
- O_VECTOR_2, out, SA_C*D_W, B-operand row slice
- O_TILE_START, out, 1, pulse on the first beat of each tile
- O_TILE_ROW, out, 16, current row-tile index
- O_TILE_COL, out, 16, current column-tile index
- O_BUSY, out, 1, high from START acceptance until the DONE pulse
- O_DONE, out, 1, one-cycle pulse when all tiles are complete

Behaviour:
- Reset: synchronous, active-high, on I_CLK; the only reset. Every output is 0, FSM goes to IDLE, all counters are 0. Reset mid-operation aborts immediately; no DONE is issued.
- Flattening: element [r][c] of an R×C matrix occupies bits ((r*C+c)*D_W) +: D_W. Vector lane i occupies bits i*D_W +: D_W.
- Geometry:
  - Mode 0: inner dimension K_IN = D_K; tile grid is SEQ/SA_R rows × SEQ/SA_C columns. A = Q. B[k][j] = K[j][k] (transpose is pure wiring).
  - Mode 1: K_IN = SEQ; tile grid is SEQ/SA_R × D_K/SA_C. A = P, B = V.
- Beat k of tile (tr,tc):
  - O_VECTOR_1 lane i = A[tr*SA_R+i][k]
  - O_VECTOR_2 lane j = B[k][tc*SA_C+j]
  - k runs from 0 to K_IN-1.
- FSM states:
  - IDLE: on I_START, latch mode, clear counters, go to FEED. O_BUSY rises on the next cycle. I_START outside IDLE is ignored.
  - FEED: O_VECTOR_VLD = 1. A beat completes when VLD and RDY are both high; k then increments. Data and VLD hold stable while RDY is low. After beat K_IN-1 completes, go to WAIT.
  - WAIT: VLD = 0; wait for I_SA_DONE.
    - If tiles remain: advance tc; on column wrap, tc goes to 0 and tr increments. Go to FEED.
    - If this was the last tile: go to DONE.
  - DONE: O_DONE = 1 for one cycle, O_BUSY falls, return to IDLE.
- Latency:
  - I_START in cycle t: first VLD in cycle t+1, with O_TILE_START = 1.
  - I_SA_DONE in cycle t (WAIT): next tile's VLD in t+1, or O_DONE in t+1 for the last tile.
- O_TILE_START is high only in the first FEED cycle of a tile (k = 0), even if that beat stalls. O_TILE_ROW and O_TILE_COL are valid while BUSY.
- I_SA_DONE outside WAIT is ignored. I_SA_DONE and a final-beat handshake in the same cycle: the DONE is ignored, because the state is still FEED.
- I_MAT_* must be stable while BUSY; they are not latched.
- When not in FEED, the O_VECTOR_1 and O_VECTOR_2 data are 0.

Test Plan:
(All scenarios use SA_R = SA_C = 2, SEQ = 4, D_K = 2, Q[r][c] = 10r+c, K[r][c] = 20+10r+c.)
1. Mode 0, RDY = 1, SA_DONE 3 cycles after each tile's last beat -> 4 tiles × 2 beats.
   - Tile (0,1) beat 1: VEC1 = {Q[0][1], Q[1][1]} = {1, 11}; VEC2 = {K[2][1], K[3][1]} = {41, 51}.
   - O_DONE once, 1 cycle after the 4th SA_DONE.
2. Mode 1 with P[r][c] = r*4+c -> 2 tiles × 4 beats. Tile (1,0) beat 3: VEC1 = {P[2][3], P[3][3]} = {11, 15}; VEC2 = {V[3][0], V[3][1]}.
3. Mode 0 with RDY toggling 1,0,0,1 -> data and VLD held through stalls; still exactly 8 accepted beats; TILE_START never pulses twice for one tile.
4. Second I_START while BUSY, plus SA_DONE pulses injected during FEED -> both ignored; tile sequence and DONE timing match scenario 1.
5. I_SYNC_RST asserted on beat 1 of tile (1,0) -> next cycle all outputs 0, no DONE. A new START then completes a full mode 0 run.
6. I_START in cycle t -> VLD and TILE_START in t+1 with ROW = COL = 0; BUSY high from t+1 until the DONE cycle.
